// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LC-3b instruction fetch unit with redirect flush and single-entry decode buffer
module fetch_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_saved_target, w_saved_target_nxt;
  logic [15:0] r_ir, w_ir_nxt;
  logic [15:0] r_if_pc, w_if_pc_nxt;
  logic [15:0] r_if_pc_plus2, w_if_pc_plus2_nxt;
  logic [15:0] w_target;
  logic [15:0] w_pc_inc;

  // Instructions are halfword aligned, so bit 0 of any loaded address is dropped.
  assign w_target = redirect_target & 16'hFFFE;
  assign w_pc_inc = r_pc + 16'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_FETCH;
      r_pc           <= 16'h0000;
      r_saved_target <= 16'h0000;
      r_ir           <= 16'h0000;
      r_if_pc        <= 16'h0000;
      r_if_pc_plus2  <= 16'h0000;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_saved_target <= w_saved_target_nxt;
      r_ir           <= w_ir_nxt;
      r_if_pc        <= w_if_pc_nxt;
      r_if_pc_plus2  <= w_if_pc_plus2_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_saved_target_nxt = r_saved_target;
    w_ir_nxt           = r_ir;
    w_if_pc_nxt        = r_if_pc;
    w_if_pc_plus2_nxt  = r_if_pc_plus2;
    case (r_state)
      ST_FETCH: begin
        if (imem_resp && !redirect) begin
          w_ir_nxt          = imem_rdata;
          w_if_pc_nxt       = r_pc;
          w_if_pc_plus2_nxt = w_pc_inc;
          w_pc_nxt          = w_pc_inc;
          w_state_nxt       = ST_HOLD;
        end else if (imem_resp && redirect) begin
          w_pc_nxt = w_target;
        end else if (redirect) begin
          // Request still in flight: remember where to go once it drains.
          w_saved_target_nxt = w_target;
          w_state_nxt        = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_FETCH;
        end else if (id_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem_resp) begin
          w_pc_nxt    = redirect ? w_target : r_saved_target;
          w_state_nxt = ST_FETCH;
        end else if (redirect) begin
          w_saved_target_nxt = w_target;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Reset gates the strobe directly so no request leaks out while reset_n is low.
  assign imem_read    = reset_n & (r_state != ST_HOLD);
  assign imem_address = r_pc;
  assign if_valid     = (r_state == ST_HOLD);
  assign if_ir        = r_ir;
  assign if_pc        = r_if_pc;
  assign if_pc_plus2  = r_if_pc_plus2;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with directed scenarios and random traffic
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic [15:0] if_ir, if_pc, if_pc_plus2;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: "buffer full" and "outstanding fetch is stale" flags plus addresses.
  logic        m_hold, m_stale;
  logic [15:0] m_pc, m_saved, m_ir, m_ipc, m_ipc2;

  logic        mem_pend = 1'b0;
  int          mem_lat = 0;
  int          mem_cnt = 0;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_target(redirect_target),
    .imem_read(imem_read), .imem_address(imem_address), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .id_ready(id_ready), .if_ir(if_ir),
    .if_pc(if_pc), .if_pc_plus2(if_pc_plus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_stale = 1'b0;
    m_pc = 16'h0000; m_saved = 16'h0000;
    m_ir = 16'h0000; m_ipc = 16'h0000; m_ipc2 = 16'h0000;
    mem_pend = 1'b0;
  endtask

  task automatic model_step(input logic resp, input logic [15:0] rd, input logic redir,
                            input logic [15:0] tgt, input logic rdy);
    logic [15:0] t;
    t = tgt & 16'hFFFE;
    if (m_hold) begin
      if (redir) begin m_pc = t; m_hold = 1'b0; end
      else if (rdy) m_hold = 1'b0;
    end else if (m_stale) begin
      if (resp) begin m_pc = redir ? t : m_saved; m_stale = 1'b0; end
      else if (redir) m_saved = t;
    end else begin
      if (resp && !redir) begin
        m_ir = rd; m_ipc = m_pc; m_ipc2 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_hold = 1'b1;
      end else if (resp) m_pc = t;
      else if (redir) begin m_saved = t; m_stale = 1'b1; end
    end
  endtask

  task automatic step(input logic resp, input logic [15:0] rd, input logic redir,
                      input logic [15:0] tgt, input logic rdy);
    imem_resp = resp; imem_rdata = rd; redirect = redir; redirect_target = tgt; id_ready = rdy;
    @(posedge clk);
    if (reset_n) model_step(resp, rd, redir, tgt, rdy);
    #2;
  endtask

  task automatic mem_drive(output logic resp, output logic [15:0] rd);
    resp = 1'b0;
    rd = 16'($urandom);
    if (imem_read) begin
      if (!mem_pend) begin mem_pend = 1'b1; mem_lat = $urandom_range(0, 3); mem_cnt = 0; end
      if (mem_cnt == mem_lat) begin resp = 1'b1; mem_pend = 1'b0; end
      else mem_cnt++;
    end
  endtask

  always @(negedge reset_n) model_reset();

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_if_valid", {15'd0, if_valid}, 16'd0);
      chk("rst_imem_read", {15'd0, imem_read}, 16'd0);
    end else begin
      chk("if_valid", {15'd0, if_valid}, {15'd0, m_hold});
      chk("imem_read", {15'd0, imem_read}, {15'd0, !m_hold});
      if (m_hold) begin
        chk("if_ir", if_ir, m_ir);
        chk("if_pc", if_pc, m_ipc);
        chk("if_pc_plus2", if_pc_plus2, m_ipc2);
      end else begin
        chk("imem_address", imem_address, m_pc);
      end
    end
  end

  initial begin
    logic        r_resp, r_redir, r_rdy;
    logic [15:0] r_rd, r_tgt;
    model_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk("s1_first_read", {15'd0, imem_read}, 16'd1);
    chk("s1_first_addr", imem_address, 16'h0000);
    step(1, 16'h1234, 0, 0, 0);
    chk("s1_valid", {15'd0, if_valid}, 16'd1);
    chk("s1_ir", if_ir, 16'h1234);
    chk("s1_pc", if_pc, 16'h0000);
    chk("s1_pc2", if_pc_plus2, 16'h0002);
    chk("s1_read", {15'd0, imem_read}, 16'd0);

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      chk("s3_stall_ir", if_ir, 16'h1234);
      chk("s3_stall_read", {15'd0, imem_read}, 16'd0);
    end
    step(0, 0, 0, 0, 1);
    chk("s3_next_addr", imem_address, 16'h0002);

    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(1, 16'hA000 + 16'(k), 0, 0, 1);
      chk("s2_valid", {15'd0, if_valid}, 16'd1);
      chk("s2_pc", if_pc, 16'(2 * k));
      step(0, 0, 0, 0, 1);
      chk("s2_one_cycle", {15'd0, if_valid}, 16'd0);
    end

    step(0, 0, 1, 16'h0010, 0);
    step(1, 16'h9999, 0, 0, 0);
    chk("s4_at_0010", imem_address, 16'h0010);
    step(0, 0, 1, 16'h0301, 0);
    chk("s4_drop_addr", imem_address, 16'h0010);
    step(0, 0, 0, 0, 0);
    step(1, 16'hDEAD, 0, 0, 0);
    chk("s4_dead_dropped", {15'd0, if_valid}, 16'd0);
    chk("s4_new_addr", imem_address, 16'h0300);
    step(1, 16'h5555, 0, 0, 0);
    chk("s4_ir", if_ir, 16'h5555);
    chk("s4_pc", if_pc, 16'h0300);

    step(0, 0, 1, 16'h0200, 0);
    step(0, 0, 1, 16'h0500, 0);
    step(0, 0, 1, 16'h0400, 0);
    step(1, 16'hBEEF, 0, 0, 0);
    chk("s5_valid", {15'd0, if_valid}, 16'd0);
    chk("s5_addr", imem_address, 16'h0400);

    step(1, 16'h0001, 1, 16'hFFFF, 0);
    chk("s6_addr", imem_address, 16'hFFFE);
    step(1, 16'h7777, 0, 0, 0);
    chk("s6_pc", if_pc, 16'hFFFE);
    chk("s6_pc2", if_pc_plus2, 16'h0000);
    step(0, 0, 0, 0, 1);
    chk("s6_wrap_addr", imem_address, 16'h0000);

    step(1, 16'h1111, 0, 0, 0);
    chk("s7_valid", {15'd0, if_valid}, 16'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("s7_async_valid", {15'd0, if_valid}, 16'd0);
    chk("s7_async_read", {15'd0, imem_read}, 16'd0);
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk("s7_restart_read", {15'd0, imem_read}, 16'd1);
    chk("s7_restart_addr", imem_address, 16'h0000);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        step(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        mem_pend = 1'b0;
        #1;
      end
      mem_drive(r_resp, r_rd);
      r_redir = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: r_tgt = 16'hFFFE;
        1: r_tgt = 16'hFFFF;
        default: r_tgt = 16'($urandom);
      endcase
      r_rdy = ($urandom_range(0, 3) != 0);
      step(r_resp, r_rd, r_redir, r_tgt, r_rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- clk  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- redirect  input  1  load-PC request from the branch/JSR/TRAP resolution logic; flushes the fetch path.
- redirect_target  input  16  new PC, lc3b_word.
- imem_read  output  1  instruction memory read strobe.
- imem_address  output  16  instruction memory byte address.
- imem_resp  input  1  one-cycle pulse: imem_rdata is valid this cycle.
- imem_rdata  input  16  instruction word.
- if_valid  output  1  if_ir/if_pc/if_pc_plus2 hold a live instruction for decode.
- id_ready  input  1  decode accepts the instruction this cycle.
- if_ir  output  16  instruction register; decode slices it, e.g. ir[15:12] opcode and ir[10:0] to the sign-extension unit.
- if_pc  output  16  address of if_ir.
- if_pc_plus2  output  16  if_pc + 2, base for PC-relative target adders.

Function
REQ-002 The block SHALL hold a 16-bit register pc, the address of the next or in-flight fetch, and a 16-bit register saved_target.
REQ-003 The block SHALL implement three states:
- FETCH: a request is outstanding.
- HOLD: an instruction is buffered for decode.
- DROP: a stale request is outstanding and its response will be discarded.
REQ-004 imem_read SHALL be 1 in FETCH and DROP, and 0 in HOLD.
REQ-005 imem_address SHALL equal pc in FETCH and DROP, and SHALL remain stable until imem_resp.
REQ-006 if_valid SHALL be 1 exactly when the state is HOLD.
REQ-007 In FETCH, when imem_resp=1 and redirect=0, the block SHALL:
- load if_ir<=imem_rdata, if_pc<=pc, if_pc_plus2<=pc+2;
- set pc<=pc+2;
- go to HOLD.
REQ-008 In FETCH, when imem_resp=1 and redirect=1, the block SHALL discard imem_rdata, set pc<=redirect_target, and stay in FETCH.
REQ-009 In FETCH, when imem_resp=0 and redirect=1, the block SHALL set saved_target<=redirect_target and go to DROP; pc SHALL be unchanged.
REQ-010 In FETCH, when imem_resp=0 and redirect=0, the block SHALL hold all state.
REQ-011 In HOLD, a transfer SHALL occur when id_ready=1 and redirect=0; the block SHALL then go to FETCH, with if_valid low the next cycle.
REQ-012 In HOLD, when redirect=1, regardless of id_ready, the block SHALL drop the buffered instruction (no transfer), set pc<=redirect_target, and go to FETCH.
REQ-013 In HOLD, when id_ready=0 and redirect=0, if_ir, if_pc and if_pc_plus2 SHALL remain stable.
REQ-014 In DROP, when imem_resp=1, the block SHALL discard imem_rdata and go to FETCH with:
- pc<=redirect_target if redirect=1;
- pc<=saved_target otherwise.
REQ-015 In DROP, when imem_resp=0 and redirect=1, the block SHALL overwrite saved_target with redirect_target and stay in DROP.
REQ-016 All PC arithmetic SHALL be modulo 2^16: 0xFFFE+2=0x0000.
REQ-017 Bit 0 of every value loaded into pc or saved_target SHALL be forced to 0.
REQ-018 Minimum latency SHALL be one cycle from imem_resp to if_valid. Peak throughput SHALL be one instruction per two cycles when imem_resp returns in the request cycle and id_ready=1.
REQ-019 The block SHALL never have more than one memory request outstanding, and SHALL never forward a response belonging to a pre-redirect address.

Reset
REQ-020 While reset_n=0, the block SHALL immediately, without waiting for clk, force:
- state=FETCH, pc=0x0000, saved_target=0x0000;
- if_ir=0x0000, if_pc=0x0000, if_pc_plus2=0x0000, if_valid=0.
REQ-021 During reset, imem_read SHALL be 0.
REQ-022 In the first cycle after reset_n rises, imem_read SHALL be 1 with imem_address=0x0000.
REQ-023 Reset asserted mid-operation in any state SHALL abandon the buffered instruction and any outstanding request; the memory is reset by the same reset_n.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release with imem_resp returning 0x1234 in the same cycle -> next cycle if_valid=1, if_ir=0x1234, if_pc=0x0000, if_pc_plus2=0x0002, imem_read=0.
- Back-to-back fetch, id_ready tied 1, 3-cycle memory latency -> if_pc sequence 0x0000, 0x0002, 0x0004; each if_valid high exactly one cycle.
- HOLD with id_ready=0 for 4 cycles -> outputs stable, imem_read=0; id_ready=1 -> next fetch address 0x0002.
- In FETCH at pc=0x0010, redirect to 0x0301 with no resp; resp 0xDEAD arrives 2 cycles later -> 0xDEAD never appears with if_valid=1; next imem_address=0x0300.
- In DROP, second redirect 0x0400, then resp -> fetch resumes at 0x0400.
- pc=0xFFFE fetch -> if_pc_plus2=0x0000, next imem_address=0x0000.
- reset_n dropped asynchronously in HOLD -> if_valid=0 before the next clk edge.
